// File: rtl/life_stepper_if.sv
// Host and cell-memory bus of the Life stepper.
// The stepper drives the memory address/write side and reports status.
interface life_stepper_if #(
  parameter int COLS = 16
);
  logic            start;
  logic            debug;
  logic            busy;
  logic            done;
  logic [15:0]     gen_count;
  logic [1:0]      array_selector;
  logic            write_enb;
  logic [COLS-1:0] alive_in_selector;
  logic [COLS-1:0] alive_out_selector;

  modport master (
    input  start, debug, alive_out_selector,
    output busy, done, gen_count,
    output array_selector, write_enb, alive_in_selector
  );

  modport slave (
    output start, debug, alive_out_selector,
    input  busy, done, gen_count,
    input  array_selector, write_enb, alive_in_selector
  );
endinterface

// File: rtl/life_stepper.sv
// One Game-of-Life generation over a 4-row cell memory:
// read all rows, compute next rows, write them back.
module life_stepper #(
  parameter int ROWS = 4,
  parameter int COLS = 16,
  parameter int WRAP = 1
) (
  input logic          clk,
  input logic          rst,
  life_stepper_if.master bus
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  typedef logic [ROWS-1:0][COLS-1:0] grid_t;
  typedef enum logic [2:0] {
    IDLE, READ, COMPUTE, WRITE, DONE
  } state_t;

  // Power-of-two sizes make the toroidal mod a plain truncation.
  function automatic logic cell_at(
    input grid_t g, input int rr, input int cc
  );
    logic [RW-1:0] ri;
    logic [CW-1:0] ci;
    ri = rr[RW-1:0];
    ci = cc[CW-1:0];
    if (WRAP == 0 &&
        (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS))
      return 1'b0;
    return g[ri][ci];
  endfunction

  function automatic logic [COLS-1:0] step_row(
    input grid_t g, input logic [RW-1:0] r
  );
    logic [COLS-1:0] res;
    logic [3:0]      n;
    int              ri;
    ri  = int'(r);
    res = '0;
    for (int c = 0; c < COLS; c++) begin
      n = 4'd0;
      for (int dr = -1; dr <= 1; dr++)
        for (int dc = -1; dc <= 1; dc++)
          if (dr != 0 || dc != 0)
            n = n + {3'd0, cell_at(g, ri + dr, c + dc)};
      res[c] = (n == 4'd3) |
               (cell_at(g, ri, c) & (n == 4'd2));
    end
    return res;
  endfunction

  state_t          state;
  logic [2:0]      cnt;
  grid_t           cur;
  grid_t           nxt;
  logic            busy_q;
  logic            done_q;
  logic            we_q;
  logic [1:0]      sel_q;
  logic [COLS-1:0] win_q;
  logic [15:0]     gen_q;
  logic [COLS-1:0] nrow;
  logic [1:0]      nidx;

  assign nidx = cnt[1:0] + 2'd1;

  always_comb begin
    nrow = step_row(cur, cnt[1:0]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      cur    <= '0;
      nxt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      we_q   <= 1'b0;
      sel_q  <= '0;
      win_q  <= '0;
      gen_q  <= '0;
    end else begin
      done_q <= 1'b0;
      we_q   <= 1'b0;
      sel_q  <= '0;
      win_q  <= '0;
      if (state != IDLE && bus.debug) begin
        state  <= IDLE;
        cnt    <= '0;
        busy_q <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.start && !bus.debug) begin
              state  <= READ;
              cnt    <= '0;
              busy_q <= 1'b1;
            end
          end
          READ: begin
            // Read data lags the address by one cycle.
            if (cnt != 3'd0)
              cur[cnt[1:0] - 2'd1] <= bus.alive_out_selector;
            if (cnt == 3'd4) begin
              state <= COMPUTE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 3'd1;
              if (cnt < 3'd3) sel_q <= nidx;
            end
          end
          COMPUTE: begin
            nxt[cnt[1:0]] <= nrow;
            if (cnt == 3'd3) begin
              state <= WRITE;
              cnt   <= '0;
              we_q  <= 1'b1;
              win_q <= nxt[0];
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
          WRITE: begin
            if (cnt == 3'd3) begin
              state  <= DONE;
              done_q <= 1'b1;
              gen_q  <= gen_q + 16'd1;
            end else begin
              cnt   <= cnt + 3'd1;
              we_q  <= 1'b1;
              sel_q <= nidx;
              win_q <= nxt[nidx];
            end
          end
          DONE: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.busy              = busy_q;
  assign bus.done              = done_q;
  assign bus.write_enb         = we_q;
  assign bus.array_selector    = sel_q;
  assign bus.alive_in_selector = win_q;
  assign bus.gen_count         = gen_q;
endmodule

// File: doc/life_stepper.md
LIFE_STEPPER -- requirements
Module: life_stepper

Interface
REQ-001 Parameter ROWS, default 4: grid rows; fixed at 4, sized to match the 4-row cell memory.
REQ-002 Parameter COLS, default 16: grid columns, equal to the memory word width.
REQ-003 Parameter WRAP, default 1: 1 = toroidal edges on rows and columns; 0 = cells outside the grid are dead.
REQ-004 Clocking and reset: one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  single rising-edge clock, shared with the cell memory.
REQ-006 rst  in  1  reset; asynchronous, active-high.
REQ-007 start  in  1  request one generation step; sampled only in IDLE.
REQ-008 debug  in  1  same signal as the memory debug/preload input; high = memory is being preloaded.
REQ-009 array_selector  out  2  memory row address for both reads and writes.
REQ-010 write_enb  out  1  memory write strobe.
REQ-011 alive_in_selector  out  COLS  next-generation row data written to memory.
REQ-012 alive_out_selector  in  COLS  memory read data; valid one cycle after array_selector is presented.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle pulse when a generation has been fully written back.
REQ-015 gen_count  out  16  number of completed generations.

Function
REQ-016 The FSM SHALL have five states, IDLE -> READ -> COMPUTE -> WRITE -> DONE -> IDLE.
REQ-017 IDLE: start=1 and debug=0 at a clock edge SHALL enter READ; start in any other state SHALL be ignored.
REQ-018 READ SHALL last 5 cycles, indexed by counter c=0..4.
- c<4: array_selector=c.
- c>=1: alive_out_selector is captured into internal row buffer cur[c-1].
REQ-019 COMPUTE SHALL last 4 cycles, producing next[r] for r=0..3, one row per cycle from cur only.
REQ-020 Next-state rule, per cell: alive = (n==3) | (cur_cell & n==2).
- n is the count of the 8 neighbours, range 0..8, held in 4 bits.
REQ-021 Neighbour indexing: WRAP=1 uses rows (r±1) mod ROWS and columns (c±1) mod COLS; WRAP=0 reads out-of-range neighbours as 0.
REQ-022 WRITE SHALL last 4 cycles: write_enb=1, array_selector=r, alive_in_selector=next[r] for r=0..3 in order.
REQ-023 write_enb SHALL be 0 in every state other than WRITE.
REQ-024 No memory write SHALL occur before all 4 rows have been read, so the update is never partially in-place.
REQ-025 DONE SHALL last 1 cycle.
- done=1 for that cycle only.
- gen_count increments by 1, modulo 2^16 (16'hFFFF wraps to 0).
- The next state is IDLE.
REQ-026 Latency: with start sampled at edge 0, done SHALL be high in cycle 14 (5 read + 4 compute + 4 write, then done), and busy SHALL be high in cycles 1-14.
REQ-027 debug=1 in any non-IDLE state SHALL abort to IDLE at the next edge.
- On abort: write_enb=0, no done pulse, gen_count unchanged.
- Memory rows already written in WRITE stay written.
REQ-028 array_selector and alive_in_selector SHALL be 0 in IDLE and DONE.

Reset
REQ-029 rst=1 SHALL immediately force all of the following, asynchronously, including mid-operation:
- state=IDLE
- busy=0, done=0, write_enb=0
- array_selector=0, alive_in_selector=0
- gen_count=0
- row buffers cleared to 0
REQ-030 After rst deasserts, the first start SHALL be accepted at the first clock edge on which start=1.

Verification
REQ-031 Blinker, WRAP=1: rows {0000,0070,0000,0000}, pulse start -> memory becomes {0020,0020,0020,0000}, done in cycle 14, gen_count=1.
REQ-032 Blinker period: a second step from {0020,0020,0020,0000} -> {0000,0070,0000,0000}, gen_count=2.
REQ-033 Edge block, WRAP=1 vs WRAP=0: rows {8001,8001,0000,0000} -> unchanged with WRAP=1; all rows 0000 with WRAP=0.
REQ-034 Abort and start-while-busy:
- debug=1 during READ c=2 -> IDLE next cycle, no write_enb, no done, gen_count unchanged.
- start pulsed while busy -> ignored, exactly one done per accepted start.
REQ-035 Reset mid-WRITE: rst at WRITE r=1 -> outputs zero at once, gen_count=0, busy=0, and a fresh start then completes normally in 14 cycles.
REQ-036 gen_count wrap: preload gen_count=16'hFFFF via repeated steps or a forced value, run one step -> gen_count=0000, done=1.
